ex_mem_pipe_stage: RTL and testbench
====================================

// Module: ex_mem_pipe_stage
// PURPOSE
// - Parametrised EX->MEM pipeline stage register with valid/ready handshake, flush and an optional 2-entry skid buffer.
// - Sits between the EX and MEM stages of the RV32I 5-stage pipeline.
// - Adds stall back-pressure, bubble insertion and qualified control outputs that a plain always-load register cannot provide.
// PARAMETERS
// - XLEN      32  width of the ALU result, store-data and PC+4 fields
// - RADDR_W   5   width of the destination register index
// - SEL_W     2   width of the write-back source select
// - SKID_EN   1   1: 2-entry skid buffer, in_ready is registered; 0: single entry, in_ready = !out_valid | out_ready
// PORTS
// - clk            in   1        rising-edge clock
// - rst            in   1        asynchronous, active-low reset
// - flush          in   1        kill all held entries and any input accepted this cycle
// - in_valid       in   1        EX stage presents an instruction
// - in_ready       out  1        stage can accept this cycle
// - rf_wen_i       in   1        register-file write enable
// - dm_wen_i       in   1        data-memory write enable
// - sel_ld_i       in   SEL_W    write-back source select
// - rd_i           in   RADDR_W  destination register
// - alu_out_i      in   XLEN     ALU result / memory address
// - dm_wd_i        in   XLEN     store data
// - pcp4_i         in   XLEN     PC+4
// - out_valid      out  1        MEM stage holds a valid instruction
// - out_ready      in   1        MEM stage consumes this cycle (0 = stall)
// - rf_wen_o, dm_wen_o, sel_ld_o, rd_o, alu_out_o, dm_wd_o, pcp4_o   out   widths as inputs
// BEHAVIOUR
// - Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
// - Latency: 1 cycle from accept to out_valid when the stage is empty. Full throughput: 1 transfer/cycle when out_ready=1.
// - Reset (rst=0, async): out_valid=0 and all payload regs=0. in_ready=1 in both modes after release.
// - Qualified outputs: rf_wen_o, dm_wen_o and rd_o are forced to 0 whenever out_valid=0, so no write and no hazard match can come from a bubble. The remaining payload holds its last value.
// - SKID_EN=1 states:
//   - EMPTY: out_valid=0, in_ready=1.
//   - HOLD: main entry valid, in_ready=1.
//   - FULL: main and skid entries valid, in_ready=0.
// - SKID_EN=1 transitions:
//   - EMPTY->HOLD on accept.
//   - HOLD->HOLD on accept & consume; main reloads from the input.
//   - HOLD->FULL on accept & !consume; input goes to skid.
//   - HOLD->EMPTY on consume & !accept.
//   - FULL->HOLD on consume; skid moves to main. No accept is possible in FULL.
// - SKID_EN=0: single entry. It loads on accept and clears valid on consume without accept. in_ready is combinational from out_ready.
// - Stall: with out_ready=0 the outputs hold stable, bit-exact, for any number of cycles.
// - Flush takes priority over every other event.
//   - Next edge: state=EMPTY, out_valid=0. An input accepted in the same cycle is discarded.
//   - in_ready during flush still follows the state rules, so the producer sees a normal accept.
// - Simultaneous flush & consume: the consume completes and the outputs shown that cycle are valid. The stage is EMPTY next cycle.
// - Reset mid-stall or while FULL: both entries are dropped immediately. No partial transfer is allowed.
// - Ordering: instructions exit strictly in accept order. The skid entry is never bypassed.
// - No arithmetic; fields pass bit-exact. Widths are fixed by the parameters with no truncation.
// STRUCTURE
// - Shared package pipe_pkg:
//   - ex_mem_t packed struct {rf_wen, dm_wen, sel_ld, rd, alu_out, dm_wd, pcp4}.
//   - Stage-state enum {ST_EMPTY, ST_HOLD, ST_FULL}.
//   - SEL_LD_* write-back select constants.
// - One sub-module, pipe_skid_buf: a generic payload-width valid/ready skid buffer with flush, instantiated with $bits(ex_mem_t).
// - The top level packs and unpacks the struct and applies output qualification.
// TESTING
// 1. Reset: assert rst=0 mid-stream with FULL occupancy -> out_valid=0 and all outputs 0 immediately; after release in_ready=1.
// 2. Streaming: 8 back-to-back instrs with out_ready=1 (alu_out_i=0x10..0x17) -> out_valid from cycle 1, one per cycle, in order, no gaps.
// 3. Stall: accept A (rd=5), drop out_ready for 4 cycles while B (rd=6) is offered -> B accepted into skid, in_ready=0 afterwards, outputs stay A. On release A then B exit.
// 4. Flush: in FULL, assert flush with in_valid=1 (C) -> next cycle out_valid=0, rf_wen_o=0, rd_o=0; C never appears.
// 5. Flush & consume in the same cycle -> the A transfer is counted and the stage is EMPTY next cycle.
// 6. SKID_EN=0: in_ready tracks !out_valid | out_ready combinationally; a random valid/ready run against a reference queue -> no loss, duplication or reorder.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the RV32I pipeline registers.
//               Holds the EX->MEM payload struct (at the default field
//               widths), the stage-occupancy state encoding and the
//               write-back source select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default field widths of the EX->MEM payload.
    localparam int DEF_XLEN    = 32;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_SEL_W   = 2;

    // Write-back source select codes carried in sel_ld.
    localparam logic [DEF_SEL_W-1:0] SEL_LD_ALU = 2'd0;
    localparam logic [DEF_SEL_W-1:0] SEL_LD_MEM = 2'd1;
    localparam logic [DEF_SEL_W-1:0] SEL_LD_PC4 = 2'd2;

    // EX->MEM payload, MSB first in declaration order.
    typedef struct packed {
        logic                   rf_wen;
        logic                   dm_wen;
        logic [DEF_SEL_W-1:0]   sel_ld;
        logic [DEF_RADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]    alu_out;
        logic [DEF_XLEN-1:0]    dm_wd;
        logic [DEF_XLEN-1:0]    pcp4;
    } ex_mem_t;

    // Occupancy of a two-entry skid stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Generic valid/ready pipeline register with flush.
//               SKID_EN=1: two entries (main + skid); in_ready depends on
//               state only, so no combinational ready path crosses it.
//               SKID_EN=0: one entry; in_ready = !out_valid | out_ready.
// Ports       : clk, rst (async, active-low), flush,
//               in_valid/in_ready/in_data   - producer side
//               out_valid/out_ready/out_data - consumer side
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic w_accept;
    logic w_consume;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            stage_st_e        r_state;
            stage_st_e        w_state_nxt;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             w_load_main_in;
            logic             w_load_main_skid;
            logic             w_load_skid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            always_comb begin
                w_state_nxt      = r_state;
                w_load_main_in   = 1'b0;
                w_load_main_skid = 1'b0;
                w_load_skid      = 1'b0;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            w_state_nxt    = ST_HOLD;
                            w_load_main_in = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (w_accept && w_consume) begin
                            w_load_main_in = 1'b1;
                        end else if (w_accept) begin
                            // Consumer stalled: park the newcomer behind main.
                            w_state_nxt = ST_FULL;
                            w_load_skid = 1'b1;
                        end else if (w_consume) begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // in_ready is low here, so only a consume can occur.
                        if (w_consume) begin
                            w_state_nxt      = ST_HOLD;
                            w_load_main_skid = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_EMPTY;
                    end
                endcase
                // Flush overrides everything; payload keeps its last value.
                if (flush) begin
                    w_state_nxt      = ST_EMPTY;
                    w_load_main_in   = 1'b0;
                    w_load_main_skid = 1'b0;
                    w_load_skid      = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main <= '0;
                    r_skid <= '0;
                end else begin
                    if (w_load_main_in) begin
                        r_main <= in_data;
                    end else if (w_load_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_load_skid) begin
                        r_skid <= in_data;
                    end
                end
            end

            assign in_ready  = (r_state != ST_FULL);
            assign out_valid = (r_state != ST_EMPTY);
            assign out_data  = r_main;
        end else begin : g_single
            logic             r_valid;
            logic [WIDTH-1:0] r_main;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_main  <= '0;
                end else begin
                    if (flush) begin
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_valid <= 1'b1;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                    if (w_accept && !flush) begin
                        r_main <= in_data;
                    end
                end
            end

            assign in_ready  = ~r_valid | out_ready;
            assign out_valid = r_valid;
            assign out_data  = r_main;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_stage
// Description : EX->MEM pipeline stage register of the RV32I 5-stage core
//               with valid/ready handshake, flush and optional skid entry.
//               Write enables and rd are forced to zero on bubbles so the
//               MEM stage and hazard logic never act on a stale entry.
// Ports       : clk, rst (async, active-low), flush
//               in_valid/in_ready + *_i fields   - from EX
//               out_valid/out_ready + *_o fields - to MEM
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rf_wen_i,
    input  logic               dm_wen_i,
    input  logic [SEL_W-1:0]   sel_ld_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]    alu_out_i,
    input  logic [XLEN-1:0]    dm_wd_i,
    input  logic [XLEN-1:0]    pcp4_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rf_wen_o,
    output logic               dm_wen_o,
    output logic [SEL_W-1:0]   sel_ld_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]    alu_out_o,
    output logic [XLEN-1:0]    dm_wd_o,
    output logic [XLEN-1:0]    pcp4_o
);

    // Payload bus laid out exactly like ex_mem_t; at default widths this is
    // $bits(ex_mem_t) and the bus can be cast to the struct directly.
    localparam int C_PAYLOAD_W = 2 + SEL_W + RADDR_W + 3 * XLEN;

    logic [C_PAYLOAD_W-1:0] w_in_payload;
    logic [C_PAYLOAD_W-1:0] w_out_payload;
    logic                   w_rf_wen;
    logic                   w_dm_wen;
    logic [SEL_W-1:0]       w_sel_ld;
    logic [RADDR_W-1:0]     w_rd;
    logic [XLEN-1:0]        w_alu_out;
    logic [XLEN-1:0]        w_dm_wd;
    logic [XLEN-1:0]        w_pcp4;

    assign w_in_payload = {rf_wen_i, dm_wen_i, sel_ld_i, rd_i,
                           alu_out_i, dm_wd_i, pcp4_i};

    pipe_skid_buf #(
        .WIDTH   (C_PAYLOAD_W),
        .SKID_EN (SKID_EN)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {w_rf_wen, w_dm_wen, w_sel_ld, w_rd,
            w_alu_out, w_dm_wd, w_pcp4} = w_out_payload;

    // Side-effecting fields are qualified by valid; data fields hold.
    assign rf_wen_o  = out_valid & w_rf_wen;
    assign dm_wen_o  = out_valid & w_dm_wen;
    assign rd_o      = out_valid ? w_rd : '0;
    assign sel_ld_o  = w_sel_ld;
    assign alu_out_o = w_alu_out;
    assign dm_wd_o   = w_dm_wd;
    assign pcp4_o    = w_pcp4;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_pipe_stage
// Description : Self-checking bench for ex_mem_pipe_stage. One instance with
//               the skid entry, one single-entry instance; each is tracked by
//               an in-order queue of accepted payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out1   = 0;
    int base;

    // Skid-enabled instance (s1_*) and single-entry instance (s0_*).
    logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    ex_mem_t     s1_in, s1_obs;
    logic        s1_rf_wen_o, s1_dm_wen_o;
    logic [1:0]  s1_sel_ld_o;
    logic [4:0]  s1_rd_o;
    logic [31:0] s1_alu_out_o, s1_dm_wd_o, s1_pcp4_o;

    logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    ex_mem_t     s0_in, s0_obs;
    logic        s0_rf_wen_o, s0_dm_wen_o;
    logic [1:0]  s0_sel_ld_o;
    logic [4:0]  s0_rd_o;
    logic [31:0] s0_alu_out_o, s0_dm_wd_o, s0_pcp4_o;

    assign s1_obs = {s1_rf_wen_o, s1_dm_wen_o, s1_sel_ld_o, s1_rd_o,
                     s1_alu_out_o, s1_dm_wd_o, s1_pcp4_o};
    assign s0_obs = {s0_rf_wen_o, s0_dm_wen_o, s0_sel_ld_o, s0_rd_o,
                     s0_alu_out_o, s0_dm_wd_o, s0_pcp4_o};

    ex_mem_pipe_stage #(.SKID_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .rf_wen_i(s1_in.rf_wen), .dm_wen_i(s1_in.dm_wen), .sel_ld_i(s1_in.sel_ld),
        .rd_i(s1_in.rd), .alu_out_i(s1_in.alu_out), .dm_wd_i(s1_in.dm_wd),
        .pcp4_i(s1_in.pcp4),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .rf_wen_o(s1_rf_wen_o), .dm_wen_o(s1_dm_wen_o), .sel_ld_o(s1_sel_ld_o),
        .rd_o(s1_rd_o), .alu_out_o(s1_alu_out_o), .dm_wd_o(s1_dm_wd_o),
        .pcp4_o(s1_pcp4_o)
    );

    ex_mem_pipe_stage #(.SKID_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .rf_wen_i(s0_in.rf_wen), .dm_wen_i(s0_in.dm_wen), .sel_ld_i(s0_in.sel_ld),
        .rd_i(s0_in.rd), .alu_out_i(s0_in.alu_out), .dm_wd_i(s0_in.dm_wd),
        .pcp4_i(s0_in.pcp4),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .rf_wen_o(s0_rf_wen_o), .dm_wen_o(s0_dm_wen_o), .sel_ld_o(s0_sel_ld_o),
        .rd_o(s0_rd_o), .alu_out_o(s0_alu_out_o), .dm_wd_o(s0_dm_wd_o),
        .pcp4_o(s0_pcp4_o)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_t mk(input logic [31:0] alu, input logic [4:0] rd);
        ex_mem_t p;
        p.rf_wen  = 1'b1;
        p.dm_wen  = alu[0];
        p.sel_ld  = SEL_LD_MEM;
        p.rd      = rd;
        p.alu_out = alu;
        p.dm_wd   = ~alu;
        p.pcp4    = alu + 32'd4;
        return p;
    endfunction

    // Scoreboard: sampled mid-cycle, i.e. with the values the next rising
    // edge will see.
    ex_mem_t q1[$];
    ex_mem_t q0[$];
    ex_mem_t e1, e0;

    always @(negedge clk) begin
        if (!rst) begin
            q1.delete();
            q0.delete();
        end else begin
            check("s1_out_valid", s1_out_valid, q1.size() != 0);
            check("s1_in_ready", s1_in_ready, q1.size() < 2);
            if (!s1_out_valid)
                check("s1_bubble_qual", {s1_rf_wen_o, s1_dm_wen_o, s1_rd_o}, 0);
            if (s1_out_valid && s1_out_ready) begin
                n_out1++;
                if (q1.size() == 0) begin
                    check("s1_spurious_out", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("s1_payload", s1_obs, e1);
                end
            end
            if (s1_flush) q1.delete();
            else if (s1_in_valid && s1_in_ready) q1.push_back(s1_in);

            check("s0_out_valid", s0_out_valid, q0.size() != 0);
            check("s0_in_ready", s0_in_ready, (q0.size() == 0) || s0_out_ready);
            if (!s0_out_valid)
                check("s0_bubble_qual", {s0_rf_wen_o, s0_dm_wen_o, s0_rd_o}, 0);
            if (s0_out_valid && s0_out_ready) begin
                if (q0.size() == 0) begin
                    check("s0_spurious_out", 1, 0);
                end else begin
                    e0 = q0.pop_front();
                    check("s0_payload", s0_obs, e0);
                end
            end
            if (s0_flush) q0.delete();
            else if (s0_in_valid && s0_in_ready) q0.push_back(s0_in);
        end
    end

    initial begin
        s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_in = '0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in = '0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", s1_out_valid, 0);
        check("rst_outputs", s1_obs, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", s1_in_ready, 1);
        check("rst0_in_ready", s0_in_ready, 1);

        // Streaming: one per cycle, in order, no gaps
        s1_out_ready = 1'b1;
        base = n_out1;
        for (int i = 0; i < 8; i++) begin
            step();
            s1_in_valid = 1'b1;
            s1_in = mk(32'h10 + i, 5'(i + 1));
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", s1_out_valid, 1);
                check("stream_alu", s1_alu_out_o, 32'h10 + i - 1);
            end
        end
        step();
        s1_in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", s1_alu_out_o, 32'h17);
        step();
        check("stream_count", n_out1 - base, 8);
        @(negedge clk);
        check("stream_empty", s1_out_valid, 0);

        // Stall: A held in main, B parked in skid
        step();
        s1_in_valid = 1'b1; s1_in = mk(32'hA0, 5'd5); s1_out_ready = 1'b1;
        step();
        s1_in = mk(32'hB0, 5'd6); s1_out_ready = 1'b0;
        @(negedge clk);
        check("stall_rd_a", s1_rd_o, 5);
        check("stall_ready_b", s1_in_ready, 1);
        step();
        s1_in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_a", s1_obs, mk(32'hA0, 5'd5));
            check("stall_not_ready", s1_in_ready, 0);
        end
        step();
        s1_out_ready = 1'b1;
        @(negedge clk);
        check("release_a", s1_rd_o, 5);
        step();
        @(negedge clk);
        check("release_b", s1_rd_o, 6);
        step();
        @(negedge clk);
        check("release_empty", s1_out_valid, 0);

        // Flush while FULL with C offered
        step();
        s1_in_valid = 1'b1; s1_in = mk(32'h200, 5'd7); s1_out_ready = 1'b0;
        step();
        s1_in = mk(32'h201, 5'd8);
        step();
        s1_in = mk(32'hC0, 5'd9); s1_flush = 1'b1;
        @(negedge clk);
        check("flush_full_ready", s1_in_ready, 0);
        step();
        s1_flush = 1'b0; s1_in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", s1_out_valid, 0);
        check("flush_rf_wen", s1_rf_wen_o, 0);
        check("flush_rd", s1_rd_o, 0);
        check("flush_ready", s1_in_ready, 1);
        s1_out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("flush_no_c", s1_out_valid, 0);
        end

        // Flush in HOLD while an input is accepted: input is discarded
        step();
        s1_in_valid = 1'b1; s1_in = mk(32'h300, 5'd10); s1_out_ready = 1'b0;
        step();
        s1_in = mk(32'hC1, 5'd11); s1_flush = 1'b1;
        @(negedge clk);
        check("flush_hold_ready", s1_in_ready, 1);
        step();
        s1_flush = 1'b0; s1_in_valid = 1'b0;
        @(negedge clk);
        check("flush_hold_empty", s1_out_valid, 0);

        // Flush and consume in the same cycle
        step();
        s1_in_valid = 1'b1; s1_in = mk(32'h400, 5'd12); s1_out_ready = 1'b0;
        step();
        s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_flush = 1'b1;
        base = n_out1;
        @(negedge clk);
        check("fc_shown_valid", s1_out_valid, 1);
        check("fc_shown_alu", s1_alu_out_o, 32'h400);
        step();
        s1_flush = 1'b0;
        check("fc_count", n_out1 - base, 1);
        @(negedge clk);
        check("fc_empty", s1_out_valid, 0);

        // Asynchronous reset while FULL
        step();
        s1_out_ready = 1'b0; s1_in_valid = 1'b1; s1_in = mk(32'h500, 5'd13);
        step();
        s1_in = mk(32'h501, 5'd14);
        step();
        s1_in_valid = 1'b0;
        check("prerst_full", s1_in_ready, 0);
        #1 rst = 1'b0;
        #1;
        check("rstfull_valid", s1_out_valid, 0);
        check("rstfull_outputs", s1_obs, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstfull_ready", s1_in_ready, 1);
        check("rstfull_empty", s1_out_valid, 0);

        // Random valid/ready traffic on both instances
        for (int c = 0; c < 400; c++) begin
            step();
            s1_in_valid  = 1'($urandom_range(0, 1));
            s1_out_ready = 1'($urandom_range(0, 1));
            s1_flush     = ($urandom_range(0, 39) == 0);
            s1_in        = mk($urandom(), 5'($urandom_range(0, 31)));
            s0_in_valid  = 1'($urandom_range(0, 1));
            s0_out_ready = 1'($urandom_range(0, 1));
            s0_flush     = ($urandom_range(0, 39) == 0);
            s0_in        = mk($urandom(), 5'($urandom_range(0, 31)));
        end
        step();
        s1_in_valid = 1'b0; s1_flush = 1'b0; s1_out_ready = 1'b1;
        s0_in_valid = 1'b0; s0_flush = 1'b0; s0_out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("drain_s1", q1.size(), 0);
        check("drain_s0", q0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
